// File: rtl/neuro_mac_engine_pkg.sv
// Shared types and helpers for the neurocore multiply-accumulate engine.
package neuro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam logic LOAD_SEL_X = 1'b0;
  localparam logic LOAD_SEL_W = 1'b1;

  // Accumulator width that cannot overflow for a DEPTH-long sum of full products.
  function automatic int acc_w(input int data_w, input int depth);
    return 2 * data_w + $clog2(depth);
  endfunction

endpackage

// File: rtl/neuro_mac_engine_lane.sv
// One dot-product lane: registered signed multiplier feeding a cleared/enabled accumulator.
module neuro_mac_lane
  import neuro_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_p0;
  logic                     vld_p0;
  logic signed [ACC_W-1:0]  acc_p1;

  // Stage p0: full-width signed product
  always_ff @(posedge clk) begin
    prod_p0 <= w * x;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= en;
  end

  // Stage p1: sign-extended accumulate
  always_ff @(posedge clk) begin
    if (rst || clr)  acc_p1 <= '0;
    else if (vld_p0) acc_p1 <= acc_p1 + {{(ACC_W - PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
  end

  assign acc = acc_p1;

endmodule

// File: rtl/neuro_mac_engine.sv
// Multi-lane signed MAC engine: operand buffers, load pointers, control FSM and result stream.
// Optional build macro NEURO_MAC_RELU_EN clamps negative results to zero on the output path.
module neuro_mac_engine
  import neuro_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 8,
  parameter int ACC_W  = acc_w(DATA_W, DEPTH)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic                       load_sel,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_clr,
  input  logic                       start,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ACC_W-1:0]           res_data,
  output logic [$clog2(LANES)-1:0]   res_lane,
  output logic                       res_last,
  output logic                       done
);

  localparam int K_W    = $clog2(DEPTH);
  localparam int WP_W   = $clog2(LANES * DEPTH);
  localparam int LANE_W = $clog2(LANES);

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] x_buf [DEPTH];
  logic signed [DATA_W-1:0] w_buf [LANES*DEPTH];
  logic signed [ACC_W-1:0]  acc_arr [LANES];

  logic [K_W-1:0]    x_ptr;
  logic [WP_W-1:0]   w_ptr;
  logic [K_W-1:0]    k;
  logic [LANE_W-1:0] lane_idx;
  logic              drained;
  logic              done_q;

  logic load_fire, start_fire, acc_clr, acc_en, res_fire, last_fire;

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef NEURO_MAC_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign load_fire  = load_valid && (state == IDLE);
  assign start_fire = start && (state == IDLE);
  assign acc_clr    = start_fire;
  assign acc_en     = (state == COMPUTE);
  assign res_fire   = res_valid && res_ready;
  assign last_fire  = res_fire && res_last;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)            state_nxt = COMPUTE;
      COMPUTE: if (k == K_W'(DEPTH - 1)) state_nxt = OUTPUT;
      OUTPUT:  if (last_fire)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b1;
    res_valid  = 1'b0;
    res_last   = 1'b0;
    case (state)
      IDLE:    begin load_ready = 1'b1; busy = 1'b0; end
      OUTPUT:  begin
        res_valid = drained;
        res_last  = drained && (lane_idx == LANE_W'(LANES - 1));
      end
      default: ;
    endcase
  end

  assign res_data = relu(acc_arr[lane_idx]);
  assign res_lane = lane_idx;
  assign done     = done_q;

  // A write in the same cycle as load_clr lands at the old pointer.
  always_ff @(posedge CLK) begin
    if (load_fire) begin
      if (load_sel == LOAD_SEL_X) x_buf[x_ptr] <= load_data;
      else                        w_buf[w_ptr] <= load_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_ptr <= '0;
      w_ptr <= '0;
    end else if (state == IDLE) begin
      if (load_clr) begin
        x_ptr <= '0;
        w_ptr <= '0;
      end else if (load_valid) begin
        if (load_sel == LOAD_SEL_X) x_ptr <= x_ptr + 1'b1;
        else w_ptr <= (w_ptr == WP_W'(LANES * DEPTH - 1)) ? '0 : w_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      k        <= '0;
      lane_idx <= '0;
      drained  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (start_fire)              k <= '0;
      else if (state == COMPUTE)   k <= k + 1'b1;
      if (last_fire)               lane_idx <= '0;
      else if (res_fire)           lane_idx <= lane_idx + 1'b1;
      // The last product is still in the lane pipeline on the first OUTPUT cycle.
      drained <= (state == OUTPUT) && !last_fire;
      done_q  <= last_fire;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [WP_W-1:0] ROW_BASE = WP_W'(l * DEPTH);
    logic [WP_W-1:0] w_idx;
    assign w_idx = ROW_BASE + WP_W'(k);

    neuro_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk (CLK),
      .rst (RESET),
      .clr (acc_clr),
      .en  (acc_en),
      .w   (w_buf[w_idx]),
      .x   (x_buf[k]),
      .acc (acc_arr[l])
    );
  end

endmodule
